// File: rtl/up_counter_reload_sched.sv
// Reload scheduler: queues reload values, strobes load into the counter each time count hits TERMINAL.
// Optional periodic mode under UP_COUNTER_RELOAD_SCHED_REPEAT_EN re-issues the last value when the queue is empty.
module up_counter_reload_sched #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [WIDTH-1:0]           req_data,
    output logic                       req_ready,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           count_in,
    output logic                       load,
    output logic [WIDTH-1:0]           data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, LOAD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             armed;
    logic             hit, fire, push, pop;

    assign hit       = (count_in == TERMINAL);
    assign req_ready = (pending != CW'(DEPTH));
    assign busy      = (state != IDLE);
    // flush suppresses both the trigger and any push arriving on the same edge
    assign fire      = (state == ARMED) && hit && armed && !flush;
    assign pop       = fire && (pending != '0);
    assign push      = req_valid && req_ready && !flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending != '0) state_nxt = ARMED;
            ARMED:   if (fire) state_nxt = LOAD;
`ifdef UP_COUNTER_RELOAD_SCHED_REPEAT_EN
            LOAD:    state_nxt = ARMED;
`else
            LOAD:    state_nxt = (pending != '0) ? ARMED : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            load    <= 1'b0;
            data    <= '0;
            armed   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            state <= state_nxt;
            load  <= fire;
            // an empty queue at a trigger only happens in periodic mode; data then repeats
            if (pop) data <= mem[rd_ptr];
            if (!hit)      armed <= 1'b1;
            else if (fire) armed <= 1'b0;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                pending <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      pending <= pending + CW'(1);
                else if (pop && !push) pending <= pending - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_data;
    end

endmodule

// File: tb/tb_up_counter_reload_sched.sv
// Directed bench for up_counter_reload_sched: vector table for queueing/ordering, hand sequences for corner cases.
module tb_up_counter_reload_sched;

`ifdef UP_COUNTER_RELOAD_SCHED_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic       flush;
    logic [7:0] count_in;
    logic       load;
    logic [7:0] data;
    logic [2:0] pending;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    up_counter_reload_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .count_in  (count_in),
        .load      (load),
        .data      (data),
        .pending   (pending),
        .busy      (busy)
    );

    typedef struct {
        bit         vld;
        logic [7:0] dat;
        bit         fl;
        logic [7:0] cnt;
        bit         e_load;
        logic [7:0] e_data;
        logic [2:0] e_pend;
        bit         e_rdy;
        bit         e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f, input logic [7:0] c);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        flush     = f;
        count_in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int el, input int ed, input int ep,
                           input int er, input int eb);
        chk({tag, ".load"},    load,      el);
        chk({tag, ".data"},    data,      ed);
        chk({tag, ".pending"}, pending,   ep);
        chk({tag, ".ready"},   req_ready, er);
        chk({tag, ".busy"},    busy,      eb);
    endtask

    initial begin
        int loads;
        bit data_ok;

        //            vld dat  fl cnt  load data pend rdy busy
        vecs.push_back('{0,   0, 0, 100, 0,   0,  0,  1, 0});   // idle after reset
        vecs.push_back('{1, 205, 0, 100, 0,   0,  1,  1, 0});   // push, still IDLE
        vecs.push_back('{0,   0, 0, 100, 0,   0,  1,  1, 1});   // ARMED
        vecs.push_back('{0,   0, 0, 100, 0,   0,  1,  1, 1});   // no terminal -> no load
        vecs.push_back('{0,   0, 0, 255, 1, 205,  0,  1, 1});   // load 205
        vecs.push_back('{0,   0, 0, 255, 0, 205,  0,  1, REP}); // load drops, data held
        vecs.push_back('{1,  10, 0, 100, 0, 205,  1,  1, REP});
        vecs.push_back('{1,  20, 0, 100, 0, 205,  2,  1, 1});
        vecs.push_back('{1,  30, 0, 100, 0, 205,  3,  1, 1});
        vecs.push_back('{1,  40, 0, 100, 0, 205,  4,  0, 1});   // full
        vecs.push_back('{1,  50, 0, 100, 0, 205,  4,  0, 1});   // ignored while full
        vecs.push_back('{0,   0, 0, 255, 1,  10,  3,  1, 1});
        vecs.push_back('{0,   0, 0, 255, 0,  10,  3,  1, 1});
        vecs.push_back('{0,   0, 0, 255, 0,  10,  3,  1, 1});   // stuck at terminal: no refire
        vecs.push_back('{0,   0, 0, 100, 0,  10,  3,  1, 1});
        vecs.push_back('{0,   0, 0, 255, 1,  20,  2,  1, 1});
        vecs.push_back('{0,   0, 0, 100, 0,  20,  2,  1, 1});
        vecs.push_back('{0,   0, 0, 255, 1,  30,  1,  1, 1});
        vecs.push_back('{0,   0, 0, 100, 0,  30,  1,  1, 1});
        vecs.push_back('{0,   0, 0, 255, 1,  40,  0,  1, 1});
        vecs.push_back('{0,   0, 0, 100, 0,  40,  0,  1, REP});
        vecs.push_back('{0,   0, 0, 100, 0,  40,  0,  1, REP}); // 50 never appears

        rst = 1'b1; req_valid = 1'b0; req_data = '0; flush = 1'b0; count_in = 8'd100;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].vld, vecs[i].dat, vecs[i].fl, vecs[i].cnt);
            chk_all($sformatf("vec%0d", i), vecs[i].e_load, vecs[i].e_data,
                    vecs[i].e_pend, vecs[i].e_rdy, vecs[i].e_busy);
        end

        step(0, 0, 1, 100);
        chk_all("flush0", 0, 40, 0, 1, 0);

        // terminal-valued reload with count stuck at terminal
        step(1, 255, 0, 255);
        step(1, 7, 0, 255);
        chk("t4.pend2", pending, 2);
        step(0, 0, 0, 255);
        chk("t4.load255", load, 1);
        chk("t4.data255", data, 255);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 255);
            chk($sformatf("t4.noload%0d", i), load, 0);
        end
        step(0, 0, 0, 100);
        chk("t4.leave", load, 0);
        step(0, 0, 0, 255);
        chk("t4.load7", load, 1);
        chk("t4.data7", data, 7);
        step(0, 0, 0, 255);
        chk("t4.drop", load, 0);
        step(0, 0, 1, 100);

        // flush while ARMED with three queued, push on the flush edge discarded
        step(1, 1, 0, 100);
        step(1, 2, 0, 100);
        step(1, 3, 0, 100);
        chk("t5.pend3", pending, 3);
        chk("t5.armed", busy, 1);
        step(1, 99, 1, 255);
        chk_all("t5.flush", 0, 7, 0, 1, 0);
        step(0, 0, 0, 255);
        chk_all("t5.after", 0, 7, 0, 1, 0);

        // async reset in the middle of a LOAD cycle
        step(1, 9, 0, 100);
        step(0, 0, 0, 100);
        step(0, 0, 0, 255);
        chk("t5.load9", load, 1);
        chk("t5.data9", data, 9);
        #1 rst = 1'b1;
        #1;
        chk_all("t5.rst", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b0;

        // periodic mode: one push, three terminal hits
        loads = 0;
        data_ok = 1'b1;
        step(1, 200, 0, 100);
        step(0, 0, 0, 100);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 255);
            if (load) begin loads++; if (data != 8'd200) data_ok = 1'b0; end
            step(0, 0, 0, 100);
            if (load) loads++;
        end
        chk("t6.loads", loads, REP ? 3 : 1);
        chk("t6.data_ok", data_ok, 1);
        chk("t6.data", data, 200);
        chk("t6.busy", busy, REP);
        step(0, 0, 1, 100);
        chk("t6.flush_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
